better_neighbor_buffer: RTL
===========================

Name: better_neighbor_buffer

Overview:
- Writer side of the better-neighbor list; the random address selector is its reader.
- Screens a stream of candidate neighbors against the current solution cost.
- Stores the indices of strictly better candidates in a small register file.
- Publishes the count as betterNeighborCount and answers registered reads at the address the random address selector chooses.

Parameters:
DEPTH, 16, number of storable neighbor indices (power of two, 2..256)
AW, 4, log2(DEPTH), internal storage address width
DW, 16, width of neighbor index and cost values

Ports:
clock  input  1  system clock, rising edge
nreset  input  1  asynchronous active-low reset
start_collect  input  1  begin new collection; clears list
valid_in  input  1  candidate present this cycle
last_in  input  1  qualifies valid_in; final candidate of the set
neighbor_index  input  DW  index of candidate neighbor
neighbor_cost  input  DW  cost of candidate (unsigned)
current_cost  input  DW  cost of current solution (unsigned, sampled on start_collect)
rd_en  input  1  read request
rd_addr  input  16  list position to read (from random address selector)
betterNeighborCount  output  16  number of stored better neighbors, 0..DEPTH
rd_data  output  DW  stored neighbor index
rd_valid  output  1  one-cycle pulse, rd_data valid
rd_err  output  1  one-cycle pulse, read address out of range
full  output  1  count == DEPTH
done_collect  output  1  level, high in DONE state

Behaviour:
- Reset, asynchronous on nreset low:
  - state=IDLE.
  - betterNeighborCount=0; rd_data=0; rd_valid=0; rd_err=0; full=0; done_collect=0.
  - Latched cost register cleared. Storage contents need not be cleared.
  - Reset mid-collection abandons the collection.
- States:
  - IDLE: wait for start_collect.
  - COLLECT: screen candidates.
  - DONE: list frozen, done_collect=1.
- Transitions:
  - start_collect in any state -> COLLECT next cycle: count cleared, current_cost latched, done_collect=0.
  - start_collect has priority. A valid_in in the same cycle is ignored.
  - COLLECT with valid_in & last_in -> DONE. That final candidate is still screened and written.
  - DONE holds until start_collect or reset.
  - valid_in outside COLLECT is ignored.
- Screening, in COLLECT with valid_in:
  - Accept when neighbor_cost < latched cost (unsigned strict).
  - Accept writes neighbor_index to storage[count] and increments count, both in the same clock edge.
  - When full, the candidate is dropped silently; count stays DEPTH.
  - Count never wraps.
- full is combinational from count.
- Reads (any state):
  - rd_en sampled on clock edge. Result is registered: 1-cycle latency.
  - rd_addr < count -> rd_data = storage[rd_addr[AW-1:0]], rd_valid=1.
  - rd_addr >= count (including count==0) -> rd_data=0, rd_err=1, rd_valid=0.
  - Range check uses count before any write in the same cycle. A read of the slot being written that cycle returns rd_err.
  - rd_data holds its last value when rd_en=0. rd_valid and rd_err are single-cycle pulses.
- Back-to-back reads are supported every cycle.

Optional Feature:
- Macro BNB_TIE_ACCEPT_EN.
- Defined: acceptance test becomes neighbor_cost <= latched cost, so equal-cost (plateau) moves are stored.
- Undefined: strict < only.
- Ports and timing are identical in both builds.

Test Plan:
- Basic collect:
  - Stimulus: reset, start_collect with current_cost=100, then candidates (idx,cost) = (3,90), (5,120), (7,100), (9,50 with last_in).
  - Required: betterNeighborCount=2 and done_collect=1 the cycle after last_in. With BNB_TIE_ACCEPT_EN, count=3.
- Read path:
  - Stimulus: after the basic collect, rd_en with rd_addr=0, then 1, then 2.
  - Required: rd_data=3 with rd_valid, then 9 with rd_valid, then rd_err=1 with rd_data=0. Each response one cycle after request.
- Overflow:
  - Stimulus: 20 candidates, all cost 0, current_cost=10.
  - Required: count saturates at 16, full=1; reads of addresses 0..15 return the first 16 indices.
- Restart and priority:
  - Stimulus: start_collect asserted together with valid_in in DONE state.
  - Required: count=0, done_collect=0, that candidate not stored. A read of address 0 afterwards gives rd_err.
- Reset mid-operation:
  - Stimulus: nreset low for 20 ns (one clock period) between clock edges during COLLECT after 2 accepts.
  - Required: count=0, state IDLE, done_collect=0 immediately. valid_in afterwards is ignored until start_collect.
- Integration:
  - Stimulus: connect to random address selector and random generator; collect 4 better neighbors, pulse start_rng_address.
  - Required: returned address always < 4; the resulting read gives rd_valid, never rd_err.

Source files
------------

// File: rtl/better_neighbor_buffer.sv
// Better-neighbor list writer: screens candidates against a latched cost and stores accepted indices.
// Optional macro BNB_TIE_ACCEPT_EN also accepts equal-cost (plateau) candidates.
module better_neighbor_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          start_collect,
  input  logic          valid_in,
  input  logic          last_in,
  input  logic [DW-1:0] neighbor_index,
  input  logic [DW-1:0] neighbor_cost,
  input  logic [DW-1:0] current_cost,
  input  logic          rd_en,
  input  logic [15:0]   rd_addr,
  output logic [15:0]   betterNeighborCount,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_err,
  output logic          full,
  output logic          done_collect
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] cost_q, cost_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_err_q, rd_err_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic cost_ok;
  logic wr_en;
  logic rd_hit;

`ifdef BNB_TIE_ACCEPT_EN
  assign cost_ok = (neighbor_cost <= cost_q);
`else
  assign cost_ok = (neighbor_cost < cost_q);
`endif

  assign full   = (count_q == CNT_MAX);
  assign wr_en  = (state_q == S_COLLECT) && valid_in && !start_collect && cost_ok && !full;
  // Range check deliberately uses the pre-write count, so a read of the slot being filled errors.
  assign rd_hit = (rd_addr < 16'(count_q));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cost_d     = cost_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;

    if (start_collect) begin
      state_d = S_COLLECT;
      count_d = '0;
      cost_d  = current_cost;
    end else begin
      if (wr_en) count_d = count_q + 1'b1;
      if (state_q == S_COLLECT && valid_in && last_in) state_d = S_DONE;
    end

    if (rd_en) begin
      rd_valid_d = rd_hit;
      rd_err_d   = !rd_hit;
      rd_data_d  = rd_hit ? mem_q[rd_addr[AW-1:0]] : '0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      cost_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cost_q     <= cost_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Storage is not reset; only slots below count are ever readable.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= neighbor_index;
  end

  assign betterNeighborCount = 16'(count_q);
  assign rd_data             = rd_data_q;
  assign rd_valid            = rd_valid_q;
  assign rd_err              = rd_err_q;
  assign done_collect        = (state_q == S_DONE);

endmodule
